// File: rtl/register_file.sv
// RV32I integer register file: x0 reads zero, two combinational reads, one clocked write, no backpressure.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // x0 has no storage; only x1..x(DEPTH-1) exist.
   logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

   logic write_ok;
   assign write_ok = (wen == 1'b1) && !rst && (rd != '0);

   always_ff @(posedge clk) begin
      for (int i = 1; i < DEPTH; i++) begin
         if (rst) begin
            regs[i] <= '0;
         end else if (write_ok && (rd == ADDR_WIDTH'(i))) begin
            regs[i] <= wdata;
         end
      end
   end

   // Reads are forced to zero while reset is asserted so stale contents never leak out.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (!rst) begin
         for (int i = 1; i < DEPTH; i++) begin
            if (rs1 == ADDR_WIDTH'(i)) rdata1 = regs[i];
            if (rs2 == ADDR_WIDTH'(i)) rdata2 = regs[i];
         end
`ifdef REG_FILE_BYPASS_EN
         if (write_ok && (rs1 == rd)) rdata1 = wdata;
         if (write_ok && (rs2 == rd)) rdata2 = wdata;
`endif
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        wen;
   logic [31:0] wdata;
   logic [31:0] rdata1;
   logic [31:0] rdata2;

   int vectors;
   int miscompares;

   logic [31:0] model [0:31];
   bit          model_valid;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .wen    (wen),
      .wdata  (wdata),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural state: what each register holds after every committed edge.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         model_valid = 1'b1;
      end else if (wen === 1'b1 && rd != 5'd0) begin
         model[rd] = wdata;
      end
   end

   function automatic logic [31:0] expect_read(input logic [4:0] idx);
      if (rst === 1'b1) return 32'h0;
      if (idx == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
      if (wen === 1'b1 && rd == idx) return wdata;
`endif
      return model[idx];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, mid-cycle away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         check("port1_vs_model", rdata1, expect_read(rs1));
         check("port2_vs_model", rdata2, expect_read(rs2));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
      #1;
   endtask

   logic [31:0] same_cycle_exp;

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_valid = 1'b0;
      rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; wen = 1'b0; wdata = '0;
      tick;
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         settle;
         check("reset_sweep_rd1", rdata1, 32'h0);
         check("reset_sweep_rd2", rdata2, 32'h0);
         tick;
      end

      rd = 5'd5; wen = 1'b1; wdata = 32'h0000_0003;
      tick;
      wen = 1'b0; rs1 = 5'd5; rs2 = 5'd2;
      settle;
      check("basic_x5", rdata1, 32'h0000_0003);
      check("basic_x2", rdata2, 32'h0000_0000);

      tick;
      rd = 5'd13; wen = 1'b0; wdata = 32'h0000_0E0F;
      tick;
      rs1 = 5'd13;
      settle;
      check("wen_low_x13", rdata1, 32'h0000_0000);

      tick;
      rd = 5'd0; wen = 1'b1; wdata = 32'hFFFF_FFFF;
      tick;
      wen = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
      settle;
      check("x0_port1", rdata1, 32'h0000_0000);
      check("x0_port2", rdata2, 32'h0000_0000);

      tick;
      rd = 5'd7; wen = 1'b1; wdata = 32'hDEAD_BEEF; rs1 = 5'd7;
`ifdef REG_FILE_BYPASS_EN
      same_cycle_exp = 32'hDEAD_BEEF;
`else
      same_cycle_exp = 32'h0000_0000;
`endif
      settle;
      check("same_cycle_x7", rdata1, same_cycle_exp);
      tick;
      wen = 1'b0;
      settle;
      check("after_edge_x7", rdata1, 32'hDEAD_BEEF);

      tick;
      rd = 5'd9; wen = 1'b1; wdata = 32'h1234_5678;
      tick;
      wen = 1'b0; rs2 = 5'd9;
      settle;
      check("x9_written", rdata2, 32'h1234_5678);
      tick;
      rst = 1'b1; wen = 1'b1; rd = 5'd9; wdata = 32'hCAFE_F00D; rs2 = 5'd9;
      settle;
      check("during_reset_x9", rdata2, 32'h0000_0000);
      tick;
      rst = 1'b0; wen = 1'b0;
      settle;
      check("reset_priority_x9", rdata2, 32'h0000_0000);
      tick;

      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         wen   = ($urandom_range(0, 3) != 0);
         rd    = 5'($urandom_range(0, 31));
         wdata = $urandom;
         rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rs2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) rd = 5'd0;
         tick;
      end

      rst = 1'b0; wen = 1'b0;
      settle;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

RV32I integer register file: 32 general-purpose registers of 32 bits, two combinational read ports and one clocked write port. Sits in the decode/execute path of the RV32I core. Source operands are addressed by rs1/rs2 and results are written back through rd. Register x0 is hardwired to zero.

## Interface
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- rs1  input  ADDR_WIDTH  read-port-1 register index.
- rs2  input  ADDR_WIDTH  read-port-2 register index.
- rd  input  ADDR_WIDTH  write register index.
- wen  input  1  write enable, active-high.
- wdata  input  DATA_WIDTH  write data.
- rdata1  output  DATA_WIDTH  contents of register rs1.
- rdata2  output  DATA_WIDTH  contents of register rs2.

## Operation
- Storage: registers x1..x31 hold state. x0 holds no state and always reads 0.
- Read:
  - rdata1 = (rs1 == 0) ? 0 : reg[rs1].
  - rdata2 = (rs2 == 0) ? 0 : reg[rs2].
  - Both reads are purely combinational and independent. Both ports may address the same register.
- Write: on a rising clk edge with rst = 0, wen = 1 and rd != 0, reg[rd] <= wdata.
- Writes with rd = 0 are discarded.
- With wen = 0, no register changes, regardless of rd and wdata.
- Reset: on a rising clk edge with rst = 1, all registers x1..x31 are cleared to 0. Reset has priority over a simultaneous write, so that write is lost.
- X/unknown wen is treated as no write. The reset requirement ensures every register has a defined value after the first reset edge.

## Timing
- Read latency: 0 cycles, combinational from rs1/rs2 and register state.
- Write latency: 1 edge. The new value is visible on a read port immediately after the rising edge that commits it.
- Same-cycle read of the register being written:
  - Without bypass, the read returns the old value until the edge.
  - With bypass, see Configuration.
- During reset, and after the reset edge, rdata1 = rdata2 = 0 for all indices.
- Reset asserted mid-operation: it takes effect on the next rising edge. Any pending write in that cycle is dropped.
- No handshake; one write per cycle maximum.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding is compiled in.
  - If wen = 1, rst = 0, rd != 0 and rs1 == rd, then rdata1 = wdata combinationally in the same cycle.
  - The same rule applies to rdata2 when rs2 == rd.
  - x0 is never bypassed.
- Undefined: no forwarding. Reads always reflect committed register state.
- The write and reset behaviour is identical in both builds.

## Test plan
- Reset then read: assert rst for 1 edge, then sweep rs1/rs2 over 0..31 -> rdata1 = rdata2 = 0 for every index.
- Basic write/read:
  - Set rd = 5, wen = 1, wdata = 0x00000003, then apply an edge.
  - Set rs1 = 5, rs2 = 2 -> rdata1 = 0x00000003, rdata2 = 0x00000000.
- Write disabled: rd = 13, wen = 0, wdata = 0x00000E0F, apply an edge, then rs1 = 13 -> rdata1 = 0x00000000 (x13 unchanged).
- x0 protection: rd = 0, wen = 1, wdata = 0xFFFFFFFF, apply an edge, then rs1 = 0, rs2 = 0 -> both read 0x00000000.
- Same-cycle read of written register:
  - Set rd = 7, wen = 1, wdata = 0xDEADBEEF, rs1 = 7, with x7 previously 0.
  - Before the edge: rdata1 = 0xDEADBEEF with REG_FILE_BYPASS_EN, else 0x00000000.
  - After the edge: 0xDEADBEEF in both builds.
- Reset priority:
  - Write x9 = 0x12345678.
  - Then apply rst = 1 and wen = 1, rd = 9, wdata = 0xCAFEF00D on the same edge.
  - Read rs2 = 9 -> 0x00000000.
